// File: rtl/spi_frame_master.sv
`timescale 1ns / 1ps
// spi_frame_master
// Frame-synchronous SPI master in the vgaclk domain. Once per video frame (falling edge
// of vsync when auto_en is set) or on an explicit start pulse it performs one WIDTH-bit
// full-duplex transfer, MSB first. The peripheral drives and samples on SCK falls; this
// master samples miso and advances mosi on SCK rises.
//
// Ports:
//   vgaclk   in   clock
//   reset    in   asynchronous, active-high reset
//   start    in   single-cycle transfer request
//   vsync    in   active-low vertical sync
//   auto_en  in   when 1, a vsync falling edge acts as start
//   tx_data  in   word to transmit, latched at trigger
//   miso     in   serial data from the peripheral
//   sck      out  SPI clock, idles low
//   mosi     out  serial data to the peripheral, MSB first, 0 between transfers
//   cs_b     out  active-low chip select
//   rx_data  out  last completed received word
//   busy     out  transfer in progress
//   done     out  one-cycle pulse when rx_data updates
//   overrun  out  sticky: a trigger arrived while busy and was dropped
module spi_frame_master #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned CLKDIV = 4
) (
  input  logic             vgaclk,
  input  logic             reset,
  input  logic             start,
  input  logic             vsync,
  input  logic             auto_en,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             miso,
  output logic             sck,
  output logic             mosi,
  output logic             cs_b,
  output logic [WIDTH-1:0] rx_data,
  output logic             busy,
  output logic             done,
  output logic             overrun
);

  // Bit counter must reach WIDTH itself to mark the final low phase.
  localparam int unsigned    CntW    = $clog2(WIDTH + 1);
  localparam logic [7:0]     DivLoad = 8'(CLKDIV - 1);
  localparam logic [CntW-1:0] AllBits = CntW'(WIDTH);

  typedef enum logic [1:0] {StIdle, StSetup, StShift, StHold} state_e;

  state_e           state_q;
  logic             vsync_q;
  logic [7:0]       cnt_q;
  logic [CntW-1:0]  bit_q;
  logic [WIDTH-1:0] tx_q;
  logic [WIDTH-1:0] rx_q;
  logic             trig;
  logic             phase_end;

  assign trig      = start | (auto_en & vsync_q & ~vsync);
  assign phase_end = (cnt_q == 8'd0);

  always_ff @(posedge vgaclk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      vsync_q <= 1'b1;
      cnt_q   <= 8'd0;
      bit_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      sck     <= 1'b0;
      mosi    <= 1'b0;
      cs_b    <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
      overrun <= 1'b0;
      rx_data <= '0;
    end else begin
      vsync_q <= vsync;
      done    <= 1'b0;

      case (state_q)
        StIdle: begin
          if (trig) begin
            tx_q    <= tx_data;
            mosi    <= tx_data[WIDTH-1];
            cnt_q   <= DivLoad;
            bit_q   <= '0;
            cs_b    <= 1'b0;
            busy    <= 1'b1;
            state_q <= StSetup;
          end
        end

        StSetup: begin
          if (!phase_end) begin
            cnt_q <= cnt_q - 8'd1;
          end else begin
            // Rise 0: mosi already holds the MSB from the trigger edge.
            cnt_q   <= DivLoad;
            sck     <= 1'b1;
            rx_q    <= {rx_q[WIDTH-2:0], miso};
            state_q <= StShift;
          end
        end

        StShift: begin
          if (!phase_end) begin
            cnt_q <= cnt_q - 8'd1;
          end else begin
            cnt_q <= DivLoad;
            if (sck) begin
              // Fall: advance to the next bit; tx_q[WIDTH-1] becomes the next mosi value.
              sck   <= 1'b0;
              bit_q <= bit_q + 1'b1;
              tx_q  <= {tx_q[WIDTH-2:0], 1'b0};
            end else if (bit_q == AllBits) begin
              // Low phase of the last bit has elapsed.
              state_q <= StHold;
            end else begin
              sck  <= 1'b1;
              rx_q <= {rx_q[WIDTH-2:0], miso};
              mosi <= tx_q[WIDTH-1];
            end
          end
        end

        StHold: begin
          if (!phase_end) begin
            cnt_q <= cnt_q - 8'd1;
          end else begin
            rx_data <= rx_q;
            done    <= 1'b1;
            busy    <= 1'b0;
            cs_b    <= 1'b1;
            mosi    <= 1'b0;
            state_q <= StIdle;
          end
        end

        default: state_q <= StIdle;
      endcase

      // Requests are never queued while a transfer is in flight.
      if (trig && (state_q != StIdle)) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_spi_frame_master.sv
`timescale 1ns / 1ps
module tb_spi_frame_master;

  localparam int W  = 32;
  localparam int C4 = 4;
  localparam int C1 = 1;

  logic vgaclk = 1'b0;
  logic reset;

  // Instance with default divider
  logic         start, vsync, auto_en;
  logic         miso = 1'b0;
  logic [W-1:0] tx_data;
  logic         sck, mosi, cs_b, busy, done, overrun;
  logic [W-1:0] rx_data;

  // Instance with minimum divider
  logic         start_b, vsync_b, auto_en_b, miso_b;
  logic [W-1:0] tx_data_b;
  logic         sck_b, mosi_b, cs_b_b, busy_b, done_b, overrun_b;
  logic [W-1:0] rx_data_b;

  assign miso_b = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 vgaclk = ~vgaclk;

  spi_frame_master #(.WIDTH(W), .CLKDIV(C4)) dut (
    .vgaclk (vgaclk),
    .reset  (reset),
    .start  (start),
    .vsync  (vsync),
    .auto_en(auto_en),
    .tx_data(tx_data),
    .miso   (miso),
    .sck    (sck),
    .mosi   (mosi),
    .cs_b   (cs_b),
    .rx_data(rx_data),
    .busy   (busy),
    .done   (done),
    .overrun(overrun)
  );

  spi_frame_master #(.WIDTH(W), .CLKDIV(C1)) dut_b (
    .vgaclk (vgaclk),
    .reset  (reset),
    .start  (start_b),
    .vsync  (vsync_b),
    .auto_en(auto_en_b),
    .tx_data(tx_data_b),
    .miso   (miso_b),
    .sck    (sck_b),
    .mosi   (mosi_b),
    .cs_b   (cs_b_b),
    .rx_data(rx_data_b),
    .busy   (busy_b),
    .done   (done_b),
    .overrun(overrun_b)
  );

  // Peripheral model: presents the MSB when selected, the next bit on each SCK fall,
  // and captures mosi on each SCK fall.
  logic [W-1:0] slv_word = '0;
  logic [W-1:0] mosi_cap = '0;
  int           rise_cnt = 0;
  int           fall_cnt = 0;
  logic         sck_prev = 1'b0;
  logic         cs_prev  = 1'b1;

  always @(sck or cs_b) begin
    if (cs_prev === 1'b1 && cs_b === 1'b0) begin
      mosi_cap = '0;
      rise_cnt = 0;
      fall_cnt = 0;
      miso     = slv_word[W-1];
    end
    if (sck_prev === 1'b0 && sck === 1'b1) rise_cnt++;
    if (cs_b === 1'b0 && sck_prev === 1'b1 && sck === 1'b0 && fall_cnt < W) begin
      mosi_cap = {mosi_cap[W-2:0], mosi};
      fall_cnt++;
      if (fall_cnt < W) miso = slv_word[W-1-fall_cnt];
    end
    sck_prev = sck;
    cs_prev  = cs_b;
  end

  logic [W-1:0] mosi_cap_b = '0;
  int           rise_cnt_b = 0;
  logic         sck_prev_b = 1'b0;
  logic         cs_prev_b  = 1'b1;

  always @(sck_b or cs_b_b) begin
    if (cs_prev_b === 1'b1 && cs_b_b === 1'b0) begin
      mosi_cap_b = '0;
      rise_cnt_b = 0;
    end
    if (sck_prev_b === 1'b0 && sck_b === 1'b1) rise_cnt_b++;
    if (cs_b_b === 1'b0 && sck_prev_b === 1'b1 && sck_b === 1'b0) begin
      mosi_cap_b = {mosi_cap_b[W-2:0], mosi_b};
    end
    sck_prev_b = sck_b;
    cs_prev_b  = cs_b_b;
  end

  // Expected SCK level n edges after the trigger edge: high during the first half of each
  // 2*c-cycle bit slot, the slots starting c cycles after the trigger.
  function automatic logic sck_model(input int n, input int c);
    int h;
    h = n / c;
    return (h % 2 == 1) && (h <= 2 * W - 1);
  endfunction

  task automatic test_reset();
    reset     = 1'b1;
    start     = 1'b0;
    vsync     = 1'b1;
    auto_en   = 1'b0;
    tx_data   = '0;
    start_b   = 1'b0;
    vsync_b   = 1'b1;
    auto_en_b = 1'b0;
    tx_data_b = '0;
    repeat (3) @(posedge vgaclk);
    #1;
    n_checks++;
    if ({sck, mosi, cs_b, busy, done, overrun} !== 6'b001000) begin
      n_fail++;
      $display("FAIL reset_ctrl: sck/mosi/cs_b/busy/done/overrun=%b want 001000",
               {sck, mosi, cs_b, busy, done, overrun});
    end
    n_checks++;
    if (rx_data !== '0) begin
      n_fail++;
      $display("FAIL reset_rx: rx_data=%h want 0", rx_data);
    end
    n_checks++;
    if ({sck_b, mosi_b, cs_b_b, busy_b, done_b, overrun_b} !== 6'b001000 || rx_data_b !== '0) begin
      n_fail++;
      $display("FAIL reset_b: ctrl=%b rx=%h want 001000 / 0",
               {sck_b, mosi_b, cs_b_b, busy_b, done_b, overrun_b}, rx_data_b);
    end
    @(negedge vgaclk);
    reset = 1'b0;
    repeat (2) @(negedge vgaclk);
  endtask

  task automatic test_basic();
    logic [W-1:0] tx, sw;
    int e;
    e = C4 * (2 * W + 2);
    for (int t = 0; t < 3; t++) begin
      tx = (t == 0) ? 32'hA5C30F96 : $urandom;
      sw = (t == 0) ? 32'h12345678 : $urandom;
      slv_word = sw;
      @(negedge vgaclk);
      tx_data = tx;
      start   = 1'b1;
      @(posedge vgaclk);
      #1;
      start   = 1'b0;
      tx_data = $urandom;
      n_checks++;
      if ({cs_b, busy, sck, mosi} !== {1'b0, 1'b1, 1'b0, tx[W-1]}) begin
        n_fail++;
        $display("FAIL basic_e0: cs_b/busy/sck/mosi=%b want %b", {cs_b, busy, sck, mosi},
                 {1'b0, 1'b1, 1'b0, tx[W-1]});
      end
      for (int n = 1; n <= e; n++) begin
        @(posedge vgaclk);
        #1;
        n_checks++;
        if (sck !== sck_model(n, C4)) begin
          n_fail++;
          $display("FAIL basic_sck: E%0d sck=%b want %b", n, sck, sck_model(n, C4));
        end
        if (n < e) begin
          n_checks++;
          if ({done, cs_b, busy} !== 3'b001) begin
            n_fail++;
            $display("FAIL basic_busy: E%0d done/cs_b/busy=%b want 001", n, {done, cs_b, busy});
          end
        end
      end
      n_checks++;
      if ({done, cs_b, busy, mosi} !== 4'b1100) begin
        n_fail++;
        $display("FAIL basic_end: done/cs_b/busy/mosi=%b want 1100", {done, cs_b, busy, mosi});
      end
      n_checks++;
      if (rx_data !== sw) begin
        n_fail++;
        $display("FAIL basic_rx: rx_data=%h want %h", rx_data, sw);
      end
      n_checks++;
      if (mosi_cap !== tx || rise_cnt != W) begin
        n_fail++;
        $display("FAIL basic_mosi: mosi=%h rises=%0d want %h / %0d", mosi_cap, rise_cnt, tx, W);
      end
      @(posedge vgaclk);
      #1;
      n_checks++;
      if ({done, overrun, cs_b} !== 3'b001 || rx_data !== sw) begin
        n_fail++;
        $display("FAIL basic_after: done/overrun/cs_b=%b rx=%h want 001 / %h",
                 {done, overrun, cs_b}, rx_data, sw);
      end
    end
  endtask

  task automatic test_auto();
    logic [W-1:0] tx, sw;
    int e;
    e  = C4 * (2 * W + 2);
    tx = $urandom;
    sw = $urandom;
    slv_word = sw;
    @(negedge vgaclk);
    auto_en = 1'b1;
    vsync   = 1'b1;
    tx_data = tx;
    repeat (2) @(negedge vgaclk);
    vsync = 1'b0;
    #1;
    n_checks++;
    if (cs_b !== 1'b1) begin
      n_fail++;
      $display("FAIL auto_early: cs_b=%b want 1", cs_b);
    end
    @(posedge vgaclk);
    #1;
    n_checks++;
    if ({cs_b, busy, mosi} !== {1'b0, 1'b1, tx[W-1]}) begin
      n_fail++;
      $display("FAIL auto_start: cs_b/busy/mosi=%b want %b", {cs_b, busy, mosi},
               {1'b0, 1'b1, tx[W-1]});
    end
    repeat (e) @(posedge vgaclk);
    #1;
    n_checks++;
    if (done !== 1'b1 || rx_data !== sw || mosi_cap !== tx) begin
      n_fail++;
      $display("FAIL auto_done: done=%b rx=%h mosi=%h want 1 / %h / %h", done, rx_data,
               mosi_cap, sw, tx);
    end
    @(negedge vgaclk);
    vsync   = 1'b1;
    auto_en = 1'b0;
    repeat (3) @(negedge vgaclk);
    vsync = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(posedge vgaclk);
      #1;
      n_checks++;
      if (cs_b !== 1'b1 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL auto_off: cycle %0d cs_b=%b busy=%b want 1 0", n, cs_b, busy);
      end
    end
    @(negedge vgaclk);
    vsync = 1'b1;
  endtask

  task automatic test_latch();
    logic [W-1:0] tx, sw;
    int e;
    e  = C4 * (2 * W + 2);
    tx = $urandom;
    sw = $urandom;
    slv_word = sw;
    @(negedge vgaclk);
    tx_data = tx;
    start   = 1'b1;
    @(posedge vgaclk);
    #1;
    start = 1'b0;
    for (int n = 1; n <= e; n++) begin
      tx_data = $urandom;
      @(posedge vgaclk);
      #1;
    end
    n_checks++;
    if (done !== 1'b1 || mosi_cap !== tx || rx_data !== sw) begin
      n_fail++;
      $display("FAIL latch: done=%b mosi=%h rx=%h want 1 / %h / %h", done, mosi_cap, rx_data,
               tx, sw);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] tx, sw, tx2, sw2;
    int e;
    e   = C4 * (2 * W + 2);
    tx  = $urandom;
    sw  = $urandom;
    tx2 = $urandom;
    sw2 = $urandom;
    slv_word = sw;
    @(negedge vgaclk);
    tx_data = tx;
    start   = 1'b1;
    @(posedge vgaclk);
    #1;
    start = 1'b0;
    for (int n = 1; n <= e; n++) begin
      @(posedge vgaclk);
      #1;
      if (n == e - 1) begin
        n_checks++;
        if (overrun !== 1'b0) begin
          n_fail++;
          $display("FAIL b2b_pre: overrun=%b want 0", overrun);
        end
        start    = 1'b1;
        tx_data  = tx2;
        slv_word = sw2;
      end
    end
    n_checks++;
    if ({done, overrun, busy} !== 3'b110 || rx_data !== sw) begin
      n_fail++;
      $display("FAIL b2b_drop: done/overrun/busy=%b rx=%h want 110 / %h", {done, overrun, busy},
               rx_data, sw);
    end
    @(posedge vgaclk);
    #1;
    start = 1'b0;
    n_checks++;
    if ({busy, cs_b, done, mosi} !== {1'b1, 1'b0, 1'b0, tx2[W-1]}) begin
      n_fail++;
      $display("FAIL b2b_accept: busy/cs_b/done/mosi=%b want %b", {busy, cs_b, done, mosi},
               {1'b1, 1'b0, 1'b0, tx2[W-1]});
    end
    repeat (e) @(posedge vgaclk);
    #1;
    n_checks++;
    if (done !== 1'b1 || rx_data !== sw2 || mosi_cap !== tx2) begin
      n_fail++;
      $display("FAIL b2b_second: done=%b rx=%h mosi=%h want 1 / %h / %h", done, rx_data,
               mosi_cap, sw2, tx2);
    end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] tx, sw;
    int e;
    int n;
    e  = C4 * (2 * W + 2);
    tx = $urandom;
    slv_word = $urandom;
    @(negedge vgaclk);
    tx_data = tx;
    start   = 1'b1;
    @(posedge vgaclk);
    #1;
    start = 1'b0;
    n = 0;
    while (rise_cnt < 10 && n < 400) begin
      @(posedge vgaclk);
      #1;
      n++;
    end
    n_checks++;
    if (rise_cnt != 10) begin
      n_fail++;
      $display("FAIL mid_reach: rises=%0d want 10", rise_cnt);
    end
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if ({sck, cs_b, busy, overrun} !== 4'b0100 || rx_data !== '0) begin
      n_fail++;
      $display("FAIL mid_abort: sck/cs_b/busy/overrun=%b rx=%h want 0100 / 0",
               {sck, cs_b, busy, overrun}, rx_data);
    end
    @(negedge vgaclk);
    reset = 1'b0;
    repeat (2) @(negedge vgaclk);
    tx = 32'hFFFF0000;
    sw = $urandom;
    slv_word = sw;
    tx_data  = tx;
    start    = 1'b1;
    @(posedge vgaclk);
    #1;
    start = 1'b0;
    repeat (e) @(posedge vgaclk);
    #1;
    n_checks++;
    if (done !== 1'b1 || rx_data !== sw || mosi_cap !== tx || cs_b !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_after: done=%b cs_b=%b rx=%h mosi=%h want 1 1 / %h / %h", done, cs_b,
               rx_data, mosi_cap, sw, tx);
    end
  endtask

  task automatic test_overrun();
    logic [W-1:0] tx, sw, tx2, sw2;
    int e;
    e   = C4 * (2 * W + 2);
    tx  = $urandom;
    sw  = $urandom;
    tx2 = $urandom;
    sw2 = $urandom;
    slv_word = sw;
    @(negedge vgaclk);
    tx_data = tx;
    start   = 1'b1;
    @(posedge vgaclk);
    #1;
    start = 1'b0;
    for (int n = 1; n <= e; n++) begin
      @(posedge vgaclk);
      #1;
      if (n == 99) begin
        n_checks++;
        if (overrun !== 1'b0) begin
          n_fail++;
          $display("FAIL ovr_pre: overrun=%b want 0", overrun);
        end
        start = 1'b1;
      end
      if (n == 100) begin
        start = 1'b0;
        n_checks++;
        if (overrun !== 1'b1 || busy !== 1'b1) begin
          n_fail++;
          $display("FAIL ovr_set: overrun=%b busy=%b want 1 1", overrun, busy);
        end
      end
    end
    n_checks++;
    if (done !== 1'b1 || overrun !== 1'b1 || rise_cnt != W || rx_data !== sw) begin
      n_fail++;
      $display("FAIL ovr_single: done=%b overrun=%b rises=%0d rx=%h want 1 1 %0d %h", done,
               overrun, rise_cnt, rx_data, W, sw);
    end
    start    = 1'b1;
    tx_data  = tx2;
    slv_word = sw2;
    @(posedge vgaclk);
    #1;
    start = 1'b0;
    n_checks++;
    if ({busy, cs_b, mosi} !== {1'b1, 1'b0, tx2[W-1]}) begin
      n_fail++;
      $display("FAIL ovr_restart: busy/cs_b/mosi=%b want %b", {busy, cs_b, mosi},
               {1'b1, 1'b0, tx2[W-1]});
    end
    repeat (e) @(posedge vgaclk);
    #1;
    n_checks++;
    if (done !== 1'b1 || rx_data !== sw2 || mosi_cap !== tx2 || overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL ovr_second: done=%b overrun=%b rx=%h mosi=%h want 1 1 %h %h", done,
               overrun, rx_data, mosi_cap, sw2, tx2);
    end
  endtask

  task automatic test_min_div();
    logic [W-1:0] tx;
    int e;
    e  = C1 * (2 * W + 2);
    tx = 32'h00000001;
    @(negedge vgaclk);
    tx_data_b = tx;
    start_b   = 1'b1;
    @(posedge vgaclk);
    #1;
    start_b = 1'b0;
    n_checks++;
    if ({cs_b_b, busy_b, mosi_b} !== 3'b010) begin
      n_fail++;
      $display("FAIL min_e0: cs_b/busy/mosi=%b want 010", {cs_b_b, busy_b, mosi_b});
    end
    for (int n = 1; n <= e; n++) begin
      @(posedge vgaclk);
      #1;
      n_checks++;
      if (sck_b !== sck_model(n, C1)) begin
        n_fail++;
        $display("FAIL min_sck: E%0d sck=%b want %b", n, sck_b, sck_model(n, C1));
      end
      if (n < e) begin
        n_checks++;
        if (done_b !== 1'b0) begin
          n_fail++;
          $display("FAIL min_early: E%0d done=%b want 0", n, done_b);
        end
      end
    end
    n_checks++;
    if (done_b !== 1'b1 || cs_b_b !== 1'b1 || rx_data_b !== 32'hFFFFFFFF) begin
      n_fail++;
      $display("FAIL min_done: done=%b cs_b=%b rx=%h want 1 1 ffffffff", done_b, cs_b_b,
               rx_data_b);
    end
    n_checks++;
    if (mosi_cap_b !== tx || rise_cnt_b != W) begin
      n_fail++;
      $display("FAIL min_mosi: mosi=%h rises=%0d want %h / %0d", mosi_cap_b, rise_cnt_b, tx, W);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_auto();
    test_latch();
    test_back_to_back();
    test_reset_mid();
    test_overrun();
    test_min_div();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
